// File: rtl/uart_8n1_pkg.sv
// Shared types and constants for the 8N1 UART slice.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 104;
  localparam int UART_DATA_BITS       = 8;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_8n1_rx.sv
// 8N1 receiver: 2-flop synchroniser, mid-bit sampling FSM and baud counter.
module uart_8n1_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_enable,
  output logic [7:0] rx_byte,
  output logic       byte_available
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  logic             rx_meta_p0;
  logic             rx_sync_p1;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] bit_idx;
  logic [7:0]       shreg;
  logic             frame_err;

  // Bring the asynchronous line into the clock domain; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_meta_p0 <= rx;
      rx_sync_p1 <= rx_meta_p0;
    end
  end

  // Frame FSM: find start edge, confirm at half bit, then sample every bit period.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RX_IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      frame_err      <= 1'b0;
      rx_byte        <= 8'h00;
      byte_available <= 1'b0;
    end else begin
      byte_available <= 1'b0;
      if (!rx_enable) begin
        state     <= RX_IDLE;
        frame_err <= 1'b0;
      end else begin
        case (state)
          RX_IDLE: begin
            if (!rx_sync_p1) begin
              state   <= RX_START;
              cnt     <= '0;
              bit_idx <= '0;
            end
          end
          RX_START: begin
            if (cnt == CNT_HALF) begin
              cnt   <= '0;
              state <= rx_sync_p1 ? RX_IDLE : RX_DATA;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RX_DATA: begin
            if (cnt == CNT_LAST) begin
              cnt     <= '0;
              shreg   <= {rx_sync_p1, shreg[7:1]};
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == IDX_LAST) state <= RX_STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RX_STOP: begin
            // A low stop bit parks here until the line is released.
            if (frame_err) begin
              if (rx_sync_p1) begin
                frame_err <= 1'b0;
                state     <= RX_IDLE;
              end
            end else if (cnt == CNT_LAST) begin
              cnt <= '0;
              if (rx_sync_p1) begin
                rx_byte        <= shreg;
                byte_available <= 1'b1;
                state          <= RX_IDLE;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_8n1.sv
// Full-duplex 8N1 UART: receiver sub-module plus inline transmitter.
module uart_8n1
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  input  logic       rx_enable,
  output logic [7:0] rx_byte,
  output logic       byte_available,
  input  logic [7:0] tx_byte,
  input  logic       tx_enable,
  output logic       tx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  tx_state_t        tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [IDX_W-1:0] tx_bit_idx;
  logic [7:0]       tx_shreg;

  uart_8n1_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .rx_enable     (rx_enable),
    .rx_byte       (rx_byte),
    .byte_available(byte_available)
  );

  // Transmit FSM: each state holds its line level for exactly one bit period.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state   <= TX_IDLE;
      tx_cnt     <= '0;
      tx_bit_idx <= '0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx <= 1'b1;
          if (tx_enable) begin
            tx_shreg <= tx_byte;
            tx_busy  <= 1'b1;
            tx       <= 1'b0;
            tx_cnt   <= '0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt     <= '0;
            tx_bit_idx <= '0;
            tx         <= tx_shreg[0];
            tx_state   <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit_idx == IDX_LAST) begin
              tx       <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx         <= tx_shreg[1];
              tx_shreg   <= {1'b0, tx_shreg[7:1]};
              tx_bit_idx <= tx_bit_idx + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt   <= '0;
            tx_busy  <= 1'b0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_8n1.sv
// Self-checking bench for uart_8n1 at 16 clocks per bit.
module tb_uart_8n1;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_enable = 1'b1;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_enable = 1'b0;
  logic       loop = 1'b0;
  logic       tx;
  logic [7:0] rx_byte;
  logic       byte_available;
  logic       tx_busy;
  logic       tx_enable_w;
  logic [7:0] tx_byte_w;

  assign tx_enable_w = loop ? byte_available : tx_enable;
  assign tx_byte_w   = loop ? rx_byte : tx_byte;

  uart_8n1 #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .tx            (tx),
    .rx_enable     (rx_enable),
    .rx_byte       (rx_byte),
    .byte_available(byte_available),
    .tx_byte       (tx_byte_w),
    .tx_enable     (tx_enable_w),
    .tx_busy       (tx_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic rst_q = 1'b1;
  logic prev_ba = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  logic [7:0] strobe_q[$];
  int strobe_t[$];
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Strobe logger: records every received byte and checks strobe shape.
  always @(negedge clk) begin
    if (byte_available === 1'b1) begin
      strobe_q.push_back(rx_byte);
      strobe_t.push_back(cyc);
      chk("strobe_width", {31'd0, prev_ba}, 32'd0);
    end
    if (rx_byte !== prev_byte)
      chk("rx_byte_hold", {31'd0, byte_available | rst_q}, 32'd1);
    prev_ba   = byte_available;
    prev_byte = rx_byte;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic send_rx(input logic [7:0] b, input bit stop_ok, output int t_start);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    t_start = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 rx = fr[i];
      if (i == 0) t_start = cyc;
      repeat (CPB - 1) @(posedge clk);
    end
    @(posedge clk); #1 rx = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  task automatic pulse_tx(input logic [7:0] b);
    @(posedge clk); #1 tx_byte = b; tx_enable = 1'b1;
    @(posedge clk); #1 tx_enable = 1'b0;
  endtask

  // Frame decoder working on line levels only: find start, sample mid-bit.
  task automatic tx_decode(output logic [7:0] b, output bit ok);
    int t;
    t = 0; ok = 1'b0; b = 8'h00;
    while (tx !== 1'b0 && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) return;
    repeat (CPB / 2) @(negedge clk);
    if (tx !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = tx;
    end
    repeat (CPB) @(negedge clk);
    if (tx !== 1'b1) return;
    ok = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
  } rx_vec_t;

  rx_vec_t vecs[$];

  initial begin
    int ts, n0, bad_tx, bad_busy, busy_cnt, lat;
    int bad_bit[10];
    logic [9:0] fr;
    logic [7:0] got, exp_b;
    bit ok;
    logic [7:0] echo[3];

    // Reset state and idle hold.
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_rx_byte", {24'd0, rx_byte}, 32'd0);
    chk("rst_ba", {31'd0, byte_available}, 32'd0);
    rst = 1'b0;
    bad_tx = 0; bad_busy = 0;
    n0 = strobe_q.size();
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (tx_busy !== 1'b0) bad_busy++;
    end
    chk("idle_tx", bad_tx, 0);
    chk("idle_busy", bad_busy, 0);
    chk("idle_strobes", strobe_q.size() - n0, 0);

    // Receive table: fixed spec cases followed by random frames.
    vecs.push_back('{8'hFF, 1'b1});
    vecs.push_back('{8'h00, 1'b1});
    vecs.push_back('{8'hA5, 1'b1});
    vecs.push_back('{8'h3C, 1'b0});
    vecs.push_back('{8'h01, 1'b1});
    for (int i = 0; i < 12; i++)
      vecs.push_back('{8'($urandom), ($urandom_range(0, 4) != 0)});
    foreach (vecs[i]) begin
      n0 = strobe_q.size();
      send_rx(vecs[i].data, vecs[i].stop_ok, ts);
      if (vecs[i].stop_ok) last_good = vecs[i].data;
      chk($sformatf("rx_count[%0d]", i), strobe_q.size() - n0, vecs[i].stop_ok ? 1 : 0);
      if (vecs[i].stop_ok && strobe_q.size() > n0) begin
        chk($sformatf("rx_data[%0d]", i), {24'd0, strobe_q[$]}, {24'd0, vecs[i].data});
        lat = strobe_t[$] - ts;
        chk($sformatf("rx_latency_le160[%0d]", i), {31'd0, (lat <= 160)}, 32'd1);
      end
      chk($sformatf("rx_byte_reg[%0d]", i), {24'd0, rx_byte}, {24'd0, last_good});
    end

    // Transmit 5A cycle by cycle, with an ignored request mid-frame.
    fr = {1'b1, 8'h5A, 1'b0};
    foreach (bad_bit[i]) bad_bit[i] = 0;
    busy_cnt = 0; bad_tx = 0;
    pulse_tx(8'h5A);
    for (int k = 1; k <= 170; k++) begin
      @(negedge clk);
      if (k <= 160) begin
        if (tx !== fr[(k - 1) / CPB]) bad_bit[(k - 1) / CPB]++;
      end else if (tx !== 1'b1) begin
        bad_tx++;
      end
      if (tx_busy === 1'b1) busy_cnt++;
      if (k == 49) begin tx_byte = 8'hFF; tx_enable = 1'b1; end
      if (k == 50) tx_enable = 1'b0;
    end
    foreach (bad_bit[i]) chk($sformatf("tx5A_bit%0d", i), bad_bit[i], 0);
    chk("tx5A_busy_cycles", busy_cnt, 160);
    chk("tx5A_idle_after", bad_tx, 0);

    // Random transmit bytes through the line decoder.
    for (int i = 0; i < 5; i++) begin
      exp_b = 8'($urandom);
      pulse_tx(exp_b);
      tx_decode(got, ok);
      chk($sformatf("tx_rand_ok[%0d]", i), {31'd0, ok}, 32'd1);
      chk($sformatf("tx_rand_data[%0d]", i), {24'd0, got}, {24'd0, exp_b});
      repeat (20) @(negedge clk);
    end

    // Loopback echo.
    loop = 1'b1;
    echo[0] = 8'hFF; echo[1] = 8'h01; echo[2] = 8'h07;
    fork
      begin
        for (int i = 0; i < 3; i++) send_rx(echo[i], 1'b1, ts);
      end
      begin
        for (int i = 0; i < 3; i++) begin
          tx_decode(got, ok);
          chk($sformatf("echo_ok[%0d]", i), {31'd0, ok}, 32'd1);
          chk($sformatf("echo_data[%0d]", i), {24'd0, got}, {24'd0, echo[i]});
        end
      end
    join
    last_good = 8'h07;
    repeat (200) @(posedge clk);
    loop = 1'b0;

    // Receiver abort by rx_enable mid-byte.
    n0 = strobe_q.size();
    fork
      send_rx(8'h55, 1'b1, ts);
      begin
        repeat (60) @(posedge clk); #2 rx_enable = 1'b0;
        repeat (120) @(posedge clk); #2 rx_enable = 1'b1;
      end
    join
    chk("abort_strobes", strobe_q.size() - n0, 0);
    chk("abort_rx_byte", {24'd0, rx_byte}, {24'd0, last_good});
    n0 = strobe_q.size();
    send_rx(8'h96, 1'b1, ts);
    chk("after_abort_count", strobe_q.size() - n0, 1);
    chk("after_abort_byte", {24'd0, rx_byte}, 32'h96);

    // Reset at cycle 70 of a tx frame, with a reception in flight.
    n0 = strobe_q.size();
    fork
      send_rx(8'hFF, 1'b1, ts);
      begin
        pulse_tx(8'h00);
        for (int k = 1; k <= 70; k++) begin
          @(negedge clk);
          if (k == 69) begin
            chk("pre_rst_tx_low", {31'd0, tx}, 32'd0);
            rst = 1'b1;
          end
          if (k == 70) begin
            chk("rst_mid_tx", {31'd0, tx}, 32'd1);
            chk("rst_mid_busy", {31'd0, tx_busy}, 32'd0);
            rst = 1'b0;
          end
        end
      end
    join
    chk("rst_mid_rx_strobes", strobe_q.size() - n0, 0);
    chk("rst_mid_rx_byte", {24'd0, rx_byte}, 32'd0);

    repeat (20) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
